// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the ALU: owns the register file, tracks
// in-flight destinations with a pending scoreboard, bypasses same-cycle
// writeback data and registers the selected operands for the ALU.

package nand_cpu_pkg;
  typedef enum logic [2:0] {
    ALU_CL   = 3'd0,
    ALU_CP   = 3'd1,
    ALU_LI   = 3'd2,
    ALU_NAND = 3'd3,
    ALU_ADD  = 3'd4,
    ALU_SUB  = 3'd5,
    ALU_SHL  = 3'd6,
    ALU_SHR  = 3'd7
  } ALU_OP;
endpackage

// Operand bundle presented to the ALU.
interface alu_input_ifc;
  import nand_cpu_pkg::*;
  logic [15:0] op0;
  logic [15:0] op1;
  ALU_OP       alu_op;
  modport out (output op0, op1, alu_op);
  modport in  (input  op0, op1, alu_op);
endinterface

module alu_operand_stage
  import nand_cpu_pkg::*;
#(
  parameter  int NUM_REGS = 16,
  localparam int RW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  ALU_OP         in_alu_op,
  input  logic [RW-1:0] in_rd,
  input  logic [RW-1:0] in_rs,
  input  logic          in_use_imm,
  input  logic [5:0]    in_imm,
  input  logic          in_wr,
  alu_input_ifc.out     alu_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_rd,
  output logic          out_wr,
  input  logic          wb_en,
  input  logic [RW-1:0] wb_rd,
  input  logic [15:0]   wb_data
);

  logic [NUM_REGS-1:0][15:0] regs;
  logic [NUM_REGS-1:0]       pending;
  logic [NUM_REGS-1:0]       wb_hit;
  logic [NUM_REGS-1:0]       eff_pend;
  logic                      use_op0, use_op1, hazard, accept;
  logic [15:0]               rd_val, rs_val, op0_nxt, op1_nxt;

  // A register being written back this cycle is no longer a hazard: its
  // value is bypassed straight from wb_data.
  always_comb begin
    wb_hit = '0;
    if (wb_en) wb_hit[wb_rd] = 1'b1;
    eff_pend = pending & ~wb_hit;
  end

  // Source usage, hazard detection and handshake.
  always_comb begin
    use_op0  = (in_alu_op != ALU_CL);
    use_op1  = !in_use_imm && (in_alu_op != ALU_CL) && (in_alu_op != ALU_CP);
    hazard   = (use_op0 && eff_pend[in_rd]) ||
               (use_op1 && eff_pend[in_rs]) ||
               (in_wr   && eff_pend[in_rd]);
    in_ready = (!out_valid || out_ready) && !hazard;
    accept   = in_valid && in_ready;
  end

  // Register reads with writeback bypass; unused operands are zeroed so the
  // ALU never sees stale or pending data on a lane it ignores.
  always_comb begin
    rd_val  = (wb_en && wb_rd == in_rd) ? wb_data : regs[in_rd];
    rs_val  = (wb_en && wb_rd == in_rs) ? wb_data : regs[in_rs];
    op0_nxt = use_op0 ? rd_val : 16'h0000;
    if (in_use_imm)   op1_nxt = {10'b0, in_imm};
    else if (use_op1) op1_nxt = rs_val;
    else              op1_nxt = 16'h0000;
  end

  // Register file write port; writes land even if the target is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        regs <= '0;
    else if (wb_en) regs[wb_rd] <= wb_data;
  end

  // Scoreboard: writeback clears, accept of a writer sets; set is applied
  // last so it wins on a same-register collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (wb_en)           pending[wb_rd] <= 1'b0;
      if (accept && in_wr) pending[in_rd] <= 1'b1;
    end
  end

  // Output register: loads on accept, drains when consumed, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      alu_in.op0    <= 16'h0000;
      alu_in.op1    <= 16'h0000;
      alu_in.alu_op <= ALU_CL;
      out_rd        <= '0;
      out_wr        <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      alu_in.op0    <= op0_nxt;
      alu_in.op1    <= op1_nxt;
      alu_in.alu_op <= in_alu_op;
      out_rd        <= in_rd;
      out_wr        <= in_wr;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, immediate path, RAW stall
// with bypass, backpressure, scoreboard set/clear collision, CL/CP source
// masking and back-to-back issue.
module tb_alu_operand_stage;
  import nand_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  ALU_OP       in_alu_op;
  logic [3:0]  in_rd, in_rs;
  logic        in_use_imm;
  logic [5:0]  in_imm;
  logic        in_wr;
  logic        out_valid, out_ready;
  logic [3:0]  out_rd;
  logic        out_wr;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  int          checks = 0;
  int          failures = 0;

  alu_input_ifc aif();

  alu_operand_stage #(.NUM_REGS(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
    .in_rd(in_rd), .in_rs(in_rs), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_wr(in_wr), .alu_in(aif), .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_wr(out_wr),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input ALU_OP op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic ui, input logic [5:0] imm, input logic wr);
    in_valid = 1'b1; in_alu_op = op; in_rd = rd; in_rs = rs;
    in_use_imm = ui; in_imm = imm; in_wr = wr;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_alu_op = ALU_CL; in_rd = '0; in_rs = '0;
    in_use_imm = 1'b0; in_imm = '0; in_wr = 1'b0;
  endtask

  task automatic wb(input logic en, input logic [3:0] rd, input logic [15:0] d);
    wb_en = en; wb_rd = rd; wb_data = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1; idle_in(); wb(1'b0, 4'd0, 16'h0);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (aif.alu_op !== ALU_CL) begin failures++; $display("FAIL reset_aluop got=%0d exp=%0d", aif.alu_op, ALU_CL); end
    checks++; if (aif.op0 !== 16'h0 || aif.op1 !== 16'h0) begin failures++; $display("FAIL reset_ops got=%h/%h exp=0/0", aif.op0, aif.op1); end
    checks++; if (out_rd !== 4'd0 || out_wr !== 1'b0) begin failures++; $display("FAIL reset_tags got=%h/%b exp=0/0", out_rd, out_wr); end
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_imm();
    wb(1'b1, 4'd2, 16'h1234); step(); wb(1'b0, 4'd0, 16'h0);
    issue(ALU_LI, 4'd2, 4'd0, 1'b1, 6'h25, 1'b1); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL imm_ready got=%b exp=1", in_ready); end
    step(); idle_in();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL imm_valid got=%b exp=1", out_valid); end
    checks++; if (aif.op0 !== 16'h1234) begin failures++; $display("FAIL imm_op0 got=%h exp=1234", aif.op0); end
    checks++; if (aif.op1 !== 16'h0025) begin failures++; $display("FAIL imm_op1 got=%h exp=0025", aif.op1); end
    checks++; if (out_rd !== 4'd2 || out_wr !== 1'b1) begin failures++; $display("FAIL imm_tags got=%h/%b exp=2/1", out_rd, out_wr); end
    checks++; if (aif.alu_op !== ALU_LI) begin failures++; $display("FAIL imm_aluop got=%0d exp=%0d", aif.alu_op, ALU_LI); end
    checks++; if (dut.pending[2] !== 1'b1) begin failures++; $display("FAIL imm_pending got=%b exp=1", dut.pending[2]); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL imm_drain got=%b exp=0", out_valid); end
    // retire the LI writeback so R2 is clean again
    wb(1'b1, 4'd2, 16'h1234); step(); wb(1'b0, 4'd0, 16'h0);
  endtask

  task automatic test_raw();
    issue(ALU_NAND, 4'd1, 4'd0, 1'b0, 6'h0, 1'b1); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_first_ready got=%b exp=1", in_ready); end
    step();
    issue(ALU_NAND, 4'd4, 4'd1, 1'b0, 6'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL raw_stall%0d got=%b exp=0", i, in_ready); end
      step();
    end
    wb(1'b1, 4'd1, 16'hBEEF); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_wb_ready got=%b exp=1", in_ready); end
    step(); idle_in(); wb(1'b0, 4'd0, 16'h0);
    checks++; if (aif.op1 !== 16'hBEEF) begin failures++; $display("FAIL raw_bypass got=%h exp=beef", aif.op1); end
    checks++; if (aif.op0 !== 16'h0000 || out_rd !== 4'd4) begin failures++; $display("FAIL raw_op0_rd got=%h/%h exp=0000/4", aif.op0, out_rd); end
    checks++; if (dut.pending[1] !== 1'b0 || dut.pending[4] !== 1'b1) begin failures++; $display("FAIL raw_pending got=%b%b exp=01", dut.pending[1], dut.pending[4]); end
    wb(1'b1, 4'd4, 16'h0004); step(); wb(1'b0, 4'd0, 16'h0);
  endtask

  task automatic test_backpressure();
    issue(ALU_NAND, 4'd7, 4'd2, 1'b0, 6'h0, 1'b0); step();
    checks++; if (aif.op1 !== 16'h1234 || out_rd !== 4'd7) begin failures++; $display("FAIL bp_first got=%h/%h exp=1234/7", aif.op1, out_rd); end
    out_ready = 1'b0;
    issue(ALU_CP, 4'd1, 4'd3, 1'b0, 6'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready%0d got=%b exp=0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || aif.op1 !== 16'h1234 || out_rd !== 4'd7 || aif.alu_op !== ALU_NAND)
        begin failures++; $display("FAIL bp_hold%0d got=%b/%h/%h exp=1/1234/7", i, out_valid, aif.op1, out_rd); end
      step();
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    step(); idle_in();
    checks++; if (aif.op0 !== 16'hBEEF || aif.op1 !== 16'h0 || out_rd !== 4'd1 || aif.alu_op !== ALU_CP)
      begin failures++; $display("FAIL bp_new got=%h/%h/%h exp=beef/0000/1", aif.op0, aif.op1, out_rd); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_simul();
    issue(ALU_NAND, 4'd5, 4'd0, 1'b0, 6'h0, 1'b1); wb(1'b1, 4'd5, 16'h5555); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL sim_ready got=%b exp=1", in_ready); end
    step(); idle_in(); wb(1'b0, 4'd0, 16'h0);
    checks++; if (aif.op0 !== 16'h5555) begin failures++; $display("FAIL sim_op0 got=%h exp=5555", aif.op0); end
    checks++; if (dut.pending[5] !== 1'b1) begin failures++; $display("FAIL sim_pending got=%b exp=1", dut.pending[5]); end
    issue(ALU_NAND, 4'd0, 4'd5, 1'b0, 6'h0, 1'b0); #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL sim_stall got=%b exp=0", in_ready); end
    idle_in(); step();
  endtask

  task automatic test_clcp();
    issue(ALU_LI, 4'd6, 4'd0, 1'b1, 6'h01, 1'b1); step();
    issue(ALU_CP, 4'd0, 4'd6, 1'b0, 6'h0, 1'b0); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL cp_ready got=%b exp=1", in_ready); end
    step();
    checks++; if (aif.op1 !== 16'h0 || aif.alu_op !== ALU_CP) begin failures++; $display("FAIL cp_op1 got=%h exp=0000", aif.op1); end
    issue(ALU_CL, 4'd6, 4'd6, 1'b0, 6'h0, 1'b0); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL cl_ready got=%b exp=1", in_ready); end
    step(); idle_in();
    checks++; if (aif.op0 !== 16'h0 || aif.op1 !== 16'h0 || out_rd !== 4'd6) begin failures++; $display("FAIL cl_ops got=%h/%h/%h exp=0000/0000/6", aif.op0, aif.op1, out_rd); end
    issue(ALU_NAND, 4'd0, 4'd6, 1'b0, 6'h0, 1'b0); #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL nand_r6_stall got=%b exp=0", in_ready); end
    idle_in(); step();
  endtask

  task automatic test_back_to_back();
    issue(ALU_NAND, 4'd2, 4'd1, 1'b0, 6'h0, 1'b0); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%b exp=1", in_ready); end
    step();
    checks++; if (aif.op0 !== 16'h1234 || aif.op1 !== 16'hBEEF) begin failures++; $display("FAIL b2b_a got=%h/%h exp=1234/beef", aif.op0, aif.op1); end
    issue(ALU_NAND, 4'd1, 4'd2, 1'b0, 6'h0, 1'b0); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%b exp=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || aif.op0 !== 16'hBEEF || aif.op1 !== 16'h1234) begin failures++; $display("FAIL b2b_b got=%h/%h exp=beef/1234", aif.op0, aif.op1); end
    issue(ALU_LI, 4'd7, 4'd0, 1'b1, 6'h3F, 1'b0); step(); idle_in();
    checks++; if (out_valid !== 1'b1 || aif.op0 !== 16'h0 || aif.op1 !== 16'h003F || out_rd !== 4'd7)
      begin failures++; $display("FAIL b2b_c got=%h/%h/%h exp=0000/003f/7", aif.op0, aif.op1, out_rd); end
    step();
  endtask

  task automatic test_reset_midstream();
    issue(ALU_LI, 4'd3, 4'd0, 1'b1, 6'h05, 1'b1); step();
    idle_in(); out_ready = 1'b0; step();
    wb(1'b1, 4'd9, 16'h9999);
    #3 rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0 || aif.alu_op !== ALU_CL) begin failures++; $display("FAIL rst_mid got=%b/%0d exp=0/%0d", out_valid, aif.alu_op, ALU_CL); end
    checks++; if (dut.pending[3] !== 1'b0) begin failures++; $display("FAIL rst_pending got=%b exp=0", dut.pending[3]); end
    step(); wb(1'b0, 4'd0, 16'h0); rst = 1'b0; out_ready = 1'b1;
    issue(ALU_NAND, 4'd3, 4'd3, 1'b0, 6'h0, 1'b0); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_r3_ready got=%b exp=1", in_ready); end
    step();
    checks++; if (aif.op0 !== 16'h0 || aif.op1 !== 16'h0) begin failures++; $display("FAIL rst_r3_ops got=%h/%h exp=0000/0000", aif.op0, aif.op1); end
    issue(ALU_NAND, 4'd5, 4'd9, 1'b0, 6'h0, 1'b0); step(); idle_in();
    checks++; if (aif.op0 !== 16'h0 || aif.op1 !== 16'h0) begin failures++; $display("FAIL rst_regs got=%h/%h exp=0000/0000", aif.op0, aif.op1); end
  endtask

  initial begin
    test_reset();
    test_imm();
    test_raw();
    test_backpressure();
    test_simul();
    test_clcp();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered operand-fetch stage that sits directly upstream of the ALU. Accepts decoded ALU instructions with a valid/ready handshake and reads the architectural register file it owns. It selects register or immediate operands, forwards same-cycle writeback data, and blocks read-after-write hazards with a per-register scoreboard. Its output drives the ALU through `alu_input_ifc.out`, tagged with a valid/ready handshake and the destination register for writeback.

## Interface
- `NUM_REGS`, 16: number of 16-bit architectural registers. Must be a power of two, at least 2.
- `RW`, `$clog2(NUM_REGS)`: register index width (derived).

Ports:
- `clk` input 1: single clock.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: decoded instruction present.
- `in_ready` output 1: stage accepts this cycle.
- `in_alu_op` input `nand_cpu_pkg::ALU_OP`: operation.
- `in_rd` input RW: destination register, also the op0 source.
- `in_rs` input RW: op1 register source.
- `in_use_imm` input 1: op1 taken from `in_imm` instead of `R[in_rs]`.
- `in_imm` input 6: immediate, zero-extended to 16 bits.
- `in_wr` input 1: instruction writes `in_rd`.
- `alu_in` `alu_input_ifc.out`: op0, op1, alu_op to the ALU.
- `out_valid` output 1: `alu_in` holds a valid instruction.
- `out_ready` input 1: downstream consumes this cycle.
- `out_rd` output RW: destination tag.
- `out_wr` output 1: write-enable tag.
- `wb_en`, `wb_rd` (RW), `wb_data` (16): writeback port, inputs.

## Operation
- Register file: `NUM_REGS` x 16 bits.
  - When `wb_en` is high, `R[wb_rd] <= wb_data` at the clock edge.
  - The write is performed whether or not `wb_rd` is pending.
- Scoreboard: one `pending` bit per register.
  - Set on accept when `in_wr` is high, for `in_rd`.
  - Cleared when `wb_en` is high, for `wb_rd`.
  - If a set and a clear hit the same register in the same cycle, the set wins.
- Source usage:
  - op0 reads `R[in_rd]` unless `in_alu_op == ALU_CL`.
  - op1 reads `R[in_rs]` unless `in_use_imm` is high or `in_alu_op` is `ALU_CL` or `ALU_CP`.
- Effective pending: `pending[r] && !(wb_en && wb_rd == r)`.
- `hazard`: any used source is effectively pending, or `in_wr` is high and `in_rd` is effectively pending (WAW).
- `in_ready = (!out_valid || out_ready) && !hazard`. `in_ready` is combinational and must not depend on `in_valid`.
- Accept means `in_valid && in_ready`. On accept the output register loads:
  - op0 = `R[in_rd]`, or `wb_data` when `wb_en && wb_rd == in_rd` (bypass).
  - op1 = `{10'b0, in_imm}` when `in_use_imm` is high, otherwise `R[in_rs]` with the same bypass rule.
  - Unused operands load 0.
  - `alu_op`, `out_rd` and `out_wr` load from the corresponding inputs.
  - `out_valid` is set to 1.
- If there is no accept and `out_ready` is high, `out_valid` clears. Payload registers hold their last value.
- Output payload is stable while `out_valid && !out_ready`.
- Reset, asynchronous, takes effect immediately (including mid-stall):
  - All registers = 0 and all pending = 0.
  - `out_valid = 0`, `alu_in.op0 = alu_in.op1 = 0`, `alu_in.alu_op = ALU_CL`, `out_rd = 0`, `out_wr = 0`.
  - Writebacks in flight at reset are discarded.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented with `out_valid = 1` after edge N.
- Throughput is 1 instruction per cycle when there are no hazards and `out_ready` stays high.
- Dependent instruction, with writeback arriving in cycle W: it stalls through cycle W-1 and is accepted in cycle W with bypassed data. There is no extra bubble.
- Writeback to `wb_rd` in the same cycle as a read of `wb_rd` returns the new `wb_data`, never the stale register.
- Back-to-back accept while the output is being consumed (`out_valid && out_ready && in_valid`, no hazard) replaces the payload with no bubble.
- `out_ready` low with a full output: `in_ready = 0`. Scoreboard updates from writeback continue.

## Test plan
- Reset:
  - Stimulus: assert `rst` mid-stream with `out_valid = 1` and `pending[3] = 1`.
  - Response: immediately `out_valid = 0` and `alu_in.alu_op = ALU_CL`. After release, reading R3 gives 0 and causes no stall.
- Immediate path:
  - Stimulus: `wb` writes R2 = 0x1234. Then issue `ALU_LI`, rd = 2, `in_use_imm = 1`, imm = 0x25, `in_wr = 1`.
  - Response: next cycle op0 = 0x1234, op1 = 0x0025, `out_rd = 2`, `out_wr = 1`. `pending[2] = 1`.
- RAW stall and bypass:
  - Stimulus: issue NAND rd = 1 (`in_wr = 1`), then NAND rd = 4, rs = 1. Hold the second 3 cycles, then writeback R1 = 0xBEEF.
  - Response: `in_ready = 0` for 3 cycles. Accepted in the writeback cycle with op1 = 0xBEEF.
- Backpressure:
  - Stimulus: `out_ready = 0` for 4 cycles while `in_valid = 1`.
  - Response: payload constant and `in_ready = 0`. When `out_ready = 1`, the new instruction loads in that same cycle.
- Simultaneous set/clear:
  - Stimulus: writeback to R5 in the same cycle as accepting `in_wr = 1`, rd = 5.
  - Response: `pending[5] = 1` afterwards. op0 = `wb_data`.
- CL/CP source masking:
  - Stimulus: R6 pending, issue `ALU_CP` rd = 0, rs = 6, `in_wr = 0`.
  - Response: accepted with no stall, op1 = 0.
